ps2_key_decoder: RTL and testbench

Receives serial scan codes from a PS/2 keyboard and produces the 11-bit `ps2_key` event word that core top levels consume: bit 10 toggle, bit 9 pressed, bit 8 extended, bits 7:0 scan code. It runs in `clk_sys` beside `hps_io`. Cores with a native PS/2 port use it as a drop-in source of the same key events. It handles line synchronisation, glitch filtering, frame assembly, E0/F0 prefix folding and timeout recovery.

---
 rtl/ps2_key_decoder.sv | 167 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver producing the 11-bit key event word
// {toggle, pressed, extended, code[7:0]}. Lines are synchronised, the clock is
// glitch-filtered, frames are assembled by a small FSM and E0/F0 prefixes are
// folded into the following scan code.
// Optional feature macro: PS2_PARITY_CHECK_EN (enforce odd parity on frames).
module ps2_key_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT     = 50000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        ps2_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [7:0]  FILT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [16:0] TMO_MAX  = 17'(TIMEOUT);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   r_filt;
  logic [7:0]             r_filt_cnt;
  logic                   w_filt_hit;
  logic                   w_fall;
  logic [16:0]            r_tmo;
  logic                   w_tmo_hit;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_ext;
  logic                   r_rel;
  logic                   w_frame_ok;
  logic                   w_discard;
`ifdef PS2_PARITY_CHECK_EN
  logic                   r_par;
`endif

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  // The filtered clock only moves after FILTER_LEN consecutive differing samples.
  assign w_filt_hit = (w_clk_s != r_filt) && (r_filt_cnt == FILT_MAX);
  assign w_fall     = w_filt_hit && r_filt;
  assign w_tmo_hit  = (r_state != IDLE) && (r_tmo == TMO_MAX);

  // Synchronise both PS/2 lines into clk_sys; reset to the idle-high level.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Stability filter on the synchronised clock; any agreeing sample restarts the count.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s == r_filt) begin
      r_filt_cnt <= '0;
    end else if (w_filt_hit) begin
      r_filt     <= w_clk_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 8'd1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and byte qualification; a filtered edge takes priority over timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_ok  = w_dat_s;
    w_discard   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    w_frame_ok  = w_dat_s && (^{r_shift, r_par});
`endif
    if (r_shift == 8'hE1) begin
      w_discard = 1'b1;
    end else if (!r_ext && !r_rel) begin
      case (r_shift)
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: w_discard = 1'b1;
        default:                                  w_discard = 1'b0;
      endcase
    end
    if (w_fall) begin
      case (r_state)
        IDLE:    if (!w_dat_s) w_state_nxt = DATA;
        DATA:    if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        PARITY:  w_state_nxt = STOP;
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_tmo_hit) begin
      w_state_nxt = IDLE;
    end
  end

  // Shift/parity capture, timeout counter, prefix flags and event output.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ext     <= 1'b0;
      r_rel     <= 1'b0;
      ps2_key   <= '0;
      ps2_err   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_par     <= 1'b0;
`endif
    end else begin
      ps2_err <= 1'b0;
      if (r_state == IDLE || w_fall || w_tmo_hit) r_tmo <= '0;
      else                                        r_tmo <= r_tmo + 17'd1;

      if (w_fall) begin
        case (r_state)
          IDLE: r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_par <= w_dat_s;
`endif
          end
          default: begin
            if (!w_frame_ok) begin
              r_ext   <= 1'b0;
              r_rel   <= 1'b0;
              ps2_err <= 1'b1;
            end else if (r_shift == 8'hE0) begin
              r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
              r_rel <= 1'b1;
            end else if (!w_discard) begin
              ps2_key <= {~ps2_key[10], ~r_rel, r_ext, r_shift};
              r_ext   <= 1'b0;
              r_rel   <= 1'b0;
            end
          end
        endcase
      end else if (w_tmo_hit) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames, prefixes, discards, parity,
// timeout recovery, clock glitch and asynchronous reset mid-frame.
module tb_ps2_key_decoder;

  localparam int SYNC = 2;
  localparam int FILT = 8;
  localparam int TMO  = 1000;
  localparam int HP   = 40;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        ps2_err;

  int n_chk  = 0;
  int n_fail = 0;
  int ev_cnt = 0;
  int er_cnt = 0;
  int ev0;
  int er0;
  logic prev_t = 1'b0;

  ps2_key_decoder #(
    .SYNC_STAGES(SYNC),
    .FILTER_LEN (FILT),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ps2_key (ps2_key),
    .ps2_err (ps2_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Count toggle flips (events) and error-high cycles, sampled away from the active edge.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (ps2_key[10] != prev_t) ev_cnt <= ev_cnt + 1;
      if (ps2_err) er_cnt <= er_cnt + 1;
    end
    prev_t <= ps2_key[10];
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk_sys) ps2_data = b;
    repeat (HP) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (HP) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11);
    ps2_data = 1'b1;
    repeat (2 * HP) @(negedge clk_sys);
  endtask

  task automatic mark();
    ev0 = ev_cnt;
    er0 = er_cnt;
  endtask

`ifdef PS2_PARITY_CHECK_EN
  localparam logic [10:0] K_BAD  = 11'h7AA;
  localparam int          EV_BAD = 0;
  localparam int          ER_BAD = 1;
  localparam logic [10:0] K_TMO  = 11'h216;
  localparam logic [10:0] K_GAP  = 11'h416;
`else
  localparam logic [10:0] K_BAD  = 11'h229;
  localparam int          EV_BAD = 1;
  localparam int          ER_BAD = 0;
  localparam logic [10:0] K_TMO  = 11'h616;
  localparam logic [10:0] K_GAP  = 11'h016;
`endif

  initial begin
    repeat (5) @(negedge clk_sys);
    check("reset_key", 32'(ps2_key), 32'h0);
    check("reset_err", 32'(ps2_err), 32'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);

    mark();
    send_byte(8'h75, 1'b0);
    check("make_75", 32'(ps2_key), 32'h675);
    check("make_75_err", 32'(er_cnt - er0), 0);

    mark();
    send_byte(8'hF0, 1'b0);
    check("f0_no_event", 32'(ev_cnt - ev0), 0);
    send_byte(8'h75, 1'b0);
    check("break_75", 32'(ps2_key), 32'h075);
    check("break_75_ev", 32'(ev_cnt - ev0), 1);

    mark();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    check("ext_break_6b", 32'(ps2_key), 32'h56B);
    check("ext_break_ev", 32'(ev_cnt - ev0), 1);
    send_byte(8'h1C, 1'b0);
    check("plain_1c", 32'(ps2_key), 32'h21C);

    mark();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hE1, 1'b0);
    check("discard_aa_e1", 32'(ev_cnt - ev0), 0);
    check("discard_key", 32'(ps2_key), 32'h21C);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hAA, 1'b0);
    check("ext_aa_emit", 32'(ps2_key), 32'h7AA);

    mark();
    send_byte(8'h29, 1'b1);
    check("bad_par_key", 32'(ps2_key), 32'(K_BAD));
    check("bad_par_ev", 32'(ev_cnt - ev0), 32'(EV_BAD));
    check("bad_par_err", 32'(er_cnt - er0), 32'(ER_BAD));

    mark();
    send_bits({1'b1, 1'b0, 8'h16, 1'b0}, 5);
    repeat (TMO + 50) @(negedge clk_sys);
    check("tmo_no_event", 32'(ev_cnt - ev0), 0);
    send_byte(8'h16, 1'b0);
    check("tmo_then_16", 32'(ps2_key), 32'(K_TMO));
    check("tmo_ev", 32'(ev_cnt - ev0), 1);
    check("tmo_err", 32'(er_cnt - er0), 0);

    mark();
    @(negedge clk_sys) ps2_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk_sys);
    check("glitch_ev", 32'(ev_cnt - ev0), 0);
    check("glitch_err", 32'(er_cnt - er0), 0);

    send_byte(8'hF0, 1'b0);
    repeat (TMO + 200) @(negedge clk_sys);
    send_byte(8'h16, 1'b0);
    check("prefix_gap_16", 32'(ps2_key), 32'(K_GAP));
    check("prefix_gap_ev", 32'(ev_cnt - ev0), 1);

    send_bits({1'b1, 1'b0, 8'h05, 1'b0}, 4);
    @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_key", 32'(ps2_key), 32'h0);
    check("async_reset_err", 32'(ps2_err), 32'h0);
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    mark();
    send_byte(8'h05, 1'b0);
    check("post_reset_05", 32'(ps2_key), 32'h605);
    check("post_reset_err", 32'(er_cnt - er0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
